// File: rtl/div_seq_nbit_pkg.sv
// Shared definitions for the sequential restoring divider.
// The state encoding is also read by the ALU/control decoder to interpret divider status.
package div_seq_nbit_pkg;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_ITER = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract,
// and keep the difference only when it did not go negative.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   p_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] p_sh;
  logic [WIDTH:0] trial;
  // P stays below the divisor, so its MSB is always clear before the shift.
  logic           p_msb_unused;

  assign p_msb_unused = p_i[WIDTH];

  always_comb begin
    p_sh  = {p_i[WIDTH-1:0], q_i[WIDTH-1]};
    trial = p_sh - {1'b0, b_i};
    if (!trial[WIDTH]) begin
      p_o = trial;
      q_o = {q_i[WIDTH-2:0], 1'b1};
    end else begin
      p_o = p_sh;
      q_o = {q_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq_nbit.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or unsigned
// per operation, with a start/busy/done handshake toward the control unit.
//
// state    | meaning
// DIV_IDLE | waiting for start
// DIV_PREP | take operand magnitudes and signs, catch divide-by-zero
// DIV_ITER | WIDTH restoring steps, one per cycle
// DIV_FIX  | apply signs and register quotient/remainder
// DIV_DONE | done pulse; a new start is accepted here as well
module div_seq_nbit
  import div_seq_nbit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH:0]   p_q;
  logic             sgn_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH:0]   p_d;
  logic [WIDTH-1:0] q_d;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_neg = sgn_q & a_q[WIDTH-1];
  assign b_neg = sgn_q & b_q[WIDTH-1];
  // MIN negates to itself, which is still the right unsigned magnitude.
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .p_i (p_q),
    .q_i (q_q),
    .b_i (b_q),
    .p_o (p_d),
    .q_o (q_d)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DIV_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      p_q     <= '0;
      sgn_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        DIV_IDLE, DIV_DONE: begin
          if (start) begin
            a_q     <= dividend;
            b_q     <= divisor;
            sgn_q   <= is_signed;
            busy_q  <= 1'b1;
            state_q <= DIV_PREP;
          end else begin
            state_q <= DIV_IDLE;
          end
        end
        DIV_PREP: begin
          p_q     <= '0;
          cnt_q   <= '0;
          q_q     <= a_mag;
          b_q     <= b_mag;
          neg_q_q <= a_neg ^ b_neg;
          neg_r_q <= a_neg;
          if (b_q == '0) begin
            quo_q   <= '1;
            rem_q   <= a_q;
            dz_q    <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DIV_DONE;
          end else begin
            state_q <= DIV_ITER;
          end
        end
        DIV_ITER: begin
          p_q   <= p_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_q <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          quo_q   <= neg_q_q ? -q_q : q_q;
          rem_q   <= neg_r_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
          dz_q    <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DIV_DONE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= DIV_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_div_seq_nbit.sv
// Randomised and directed bench for div_seq_nbit at WIDTH=32 and WIDTH=8,
// checked every cycle against an arithmetic reference model.
module tb_div_seq_nbit;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st [2];
  logic        sg [2];
  logic [63:0] a_in [2];
  logic [63:0] b_in [2];
  logic        bsy [2];
  logic        dn [2];
  logic        dzo [2];
  logic [31:0] q32, r32;
  logic [7:0]  q8, r8;

  exp_t expq [2][$];
  exp_t held [2];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  div_seq_nbit #(.WIDTH(32)) dut32 (
    .clock(clk), .reset_n(rst_n), .start(st[0]), .is_signed(sg[0]),
    .dividend(a_in[0][31:0]), .divisor(b_in[0][31:0]),
    .busy(bsy[0]), .done(dn[0]), .quotient(q32), .remainder(r32),
    .div_by_zero(dzo[0])
  );

  div_seq_nbit #(.WIDTH(8)) dut8 (
    .clock(clk), .reset_n(rst_n), .start(st[1]), .is_signed(sg[1]),
    .dividend(a_in[1][7:0]), .divisor(b_in[1][7:0]),
    .busy(bsy[1]), .done(dn[1]), .quotient(q8), .remainder(r8),
    .div_by_zero(dzo[1])
  );

  function automatic int wid(input int i);
    return (i == 0) ? 32 : 8;
  endfunction

  // Reference: plain integer division on w-bit operands.
  function automatic void model(input int w, input logic [63:0] a_raw, input logic [63:0] b_raw,
                                input logic s, output logic [63:0] q, output logic [63:0] r,
                                output logic dz);
    logic [63:0] mask, a, b;
    longint sa, sb, qq, rr;
    mask = (64'd1 << w) - 64'd1;
    a = a_raw & mask;
    b = b_raw & mask;
    if (b == 64'd0) begin
      q = mask; r = a; dz = 1'b1;
    end else if (s) begin
      sa = longint'(a);
      sb = longint'(b);
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
      qq = sa / sb;
      rr = sa % sb;
      q = qq; q = q & mask;
      r = rr; r = r & mask;
      dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  task automatic check(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (w%0d) at cycle %0d: got %h, expected %h", nm, wid(i), cyc, act, exp);
  endtask

  always @(negedge clk) begin
    logic [63:0] aq, ar;
    logic ad, ab, adz;
    for (int i = 0; i < 2; i++) begin
      aq  = (i == 0) ? {32'd0, q32} : {56'd0, q8};
      ar  = (i == 0) ? {32'd0, r32} : {56'd0, r8};
      ad  = dn[i];
      ab  = bsy[i];
      adz = dzo[i];
      if (!rst_n) begin
        check("rst_done", i, {63'd0, ad}, 64'd0);
        check("rst_busy", i, {63'd0, ab}, 64'd0);
        check("rst_q", i, aq, 64'd0);
        check("rst_r", i, ar, 64'd0);
        check("rst_dz", i, {63'd0, adz}, 64'd0);
      end else if (expq[i].size() != 0 && expq[i][0].due == cyc) begin
        check("done", i, {63'd0, ad}, 64'd1);
        check("busy_at_done", i, {63'd0, ab}, 64'd0);
        check("quotient", i, aq, expq[i][0].q);
        check("remainder", i, ar, expq[i][0].r);
        check("div_by_zero", i, {63'd0, adz}, {63'd0, expq[i][0].dz});
        held[i] = expq[i].pop_front();
      end else begin
        check("no_done", i, {63'd0, ad}, 64'd0);
        check("busy", i, {63'd0, ab}, {63'd0, expq[i].size() != 0});
        check("held_q", i, aq, held[i].q);
        check("held_r", i, ar, held[i].r);
        check("held_dz", i, {63'd0, adz}, {63'd0, held[i].dz});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; the next edge is the accepting one.
  task automatic issue(input int i, input logic [63:0] a, input logic [63:0] b, input logic s);
    exp_t e;
    st[i] = 1'b1; a_in[i] = a; b_in[i] = b; sg[i] = s;
    step();
    st[i] = 1'b0;
    model(wid(i), a, b, s, e.q, e.r, e.dz);
    e.due = cyc + (e.dz ? 1 : wid(i) + 2);
    expq[i].push_back(e);
    a_in[i] = {$urandom, $urandom};
    b_in[i] = {$urandom, $urandom};
    sg[i]   = ~s;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (expq[i].size() != 0 && n < 200) begin step(); n++; end
    if (n >= 200) begin
      n_chk++;
      $display("FAIL wait_idle (w%0d): no completion within 200 cycles", wid(i));
    end
  endtask

  task automatic wait_due(input int i);
    int n = 0;
    while (expq[i].size() != 0 && cyc != expq[i][0].due && n < 200) begin step(); n++; end
    if (n >= 200) begin
      n_chk++;
      $display("FAIL wait_due (w%0d): done cycle not reached within 200 cycles", wid(i));
    end
  endtask

  function automatic logic [63:0] rand_div32();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'($urandom_range(1, 20));
      2:       return 64'hFFFF_FFFF;
      3:       return 64'h8000_0000;
      default: return 64'($urandom);
    endcase
  endfunction

  logic [63:0] da [8] = '{64'd100, -64'sd100, 64'd100, 64'hFFFF_FFFF, 64'd5, 64'd5, 64'd9, 64'h8000_0000};
  logic [63:0] db [8] = '{64'd7, 64'd7, -64'sd7, 64'h8000_0000, 64'd0, 64'd0, 64'd3, 64'hFFFF_FFFF};
  logic        ds [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    logic [63:0] mq, mr;
    logic mdz;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; sg[i] = 1'b0; a_in[i] = '0; b_in[i] = '0;
      held[i].q = '0; held[i].r = '0; held[i].dz = 1'b0; held[i].due = 0;
    end

    model(32, 64'd100, 64'd7, 1'b0, mq, mr, mdz);
    check("pin_u100_7", 0, {mq[31:0], mr[31:0]}, {32'd14, 32'd2});
    model(32, -64'sd100, 64'd7, 1'b1, mq, mr, mdz);
    check("pin_sm100_7", 0, {mq[31:0], mr[31:0]}, {32'hFFFF_FFF2, 32'hFFFF_FFFE});
    model(32, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, mq, mr, mdz);
    check("pin_min_m1", 0, {mq[31:0], mr[31:0]}, {32'h8000_0000, 32'd0});
    model(8, 64'h80, 64'h03, 1'b1, mq, mr, mdz);
    check("pin_s8", 1, {mq[31:0], mr[31:0]}, {32'hD6, 32'hFE});
    model(32, 64'd5, 64'd0, 1'b1, mq, mr, mdz);
    check("pin_dz", 0, {mq[31:0], mr[31:0], 31'd0, mdz}, {32'hFFFF_FFFF, 32'd5, 32'd1});

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    for (int k = 0; k < 8; k++) begin
      issue(0, da[k], db[k], ds[k]);
      wait_idle(0);
    end

    issue(0, 64'd1000, 64'd9, 1'b0);
    wait_due(0);
    issue(0, 64'd77, -64'sd5, 1'b1);
    wait_idle(0);

    issue(0, 64'd12345678, 64'd1234, 1'b1);
    repeat (11) step();
    st[0] = 1'b1; a_in[0] = 64'd50; b_in[0] = 64'd0; sg[0] = 1'b0;
    step();
    st[0] = 1'b0;
    repeat (5) begin
      a_in[0] = {$urandom, $urandom}; b_in[0] = {$urandom, $urandom}; sg[0] = ~sg[0];
      step();
    end
    wait_idle(0);

    issue(0, 64'd999999, 64'd13, 1'b0);
    repeat (17) step();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expq[i].delete();
      held[i].q = '0; held[i].r = '0; held[i].dz = 1'b0;
    end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    issue(1, 64'd255, 64'd16, 1'b0);
    wait_idle(1);
    issue(1, 64'h80, 64'h03, 1'b1);
    wait_idle(1);

    repeat (40) begin
      issue(0, ($urandom_range(0, 7) == 0) ? 64'h8000_0000 : 64'($urandom), rand_div32(),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) wait_due(0);
      else wait_idle(0);
    end
    wait_idle(0);

    repeat (40) begin
      issue(1, 64'($urandom_range(0, 255)),
            ($urandom_range(0, 5) == 0) ? 64'd0 : 64'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) wait_due(1);
      else wait_idle(1);
    end
    wait_idle(1);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
